// File: rtl/quant_pack.sv
// Packs signed quantised elements into LANES-wide words and buffers them in a small FIFO.
// Define QUANT_PACK_DROP_CNT_EN to build the saturating dropped-element counter.
module quant_pack #(
  parameter int D_W        = 8,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_W-1:0]       in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [D_W*LANES-1:0] m_data,
  output logic [LANES-1:0]     m_keep,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 ovf,
  output logic [15:0]          drop_cnt
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = D_W * LANES;

  logic [LW-1:0] r_lane_cnt;
  logic [WW-1:0] r_pack;
  logic          r_ovf;

  logic [WW-1:0]    r_mem_data [FIFO_DEPTH];
  logic [LANES-1:0] r_mem_keep [FIFO_DEPTH];
  logic             r_mem_last [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_full;
  logic             w_accept;
  logic             w_drop;
  logic             w_last_lane;
  logic             w_complete;
  logic             w_pop;
  logic [WW-1:0]    w_word;
  logic [LANES-1:0] w_keep;

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign in_ready    = !w_full;
  assign w_accept    = in_valid && in_ready;
  assign w_drop      = in_valid && !in_ready;
  assign w_last_lane = (r_lane_cnt == LW'(LANES - 1));
  assign w_complete  = w_accept && (w_last_lane || in_last);
  assign m_valid     = (r_count != '0);
  assign w_pop       = m_valid && m_ready;

  // Lanes above lane_cnt stay zero because r_pack is cleared on every completion.
  always_comb begin
    w_word = r_pack;
    w_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LW'(i) == r_lane_cnt) w_word[i*D_W +: D_W] = in_data;
      w_keep[i] = (LW'(i) <= r_lane_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane_cnt <= '0;
      r_pack     <= '0;
    end else if (w_complete) begin
      r_lane_cnt <= '0;
      r_pack     <= '0;
    end else if (w_accept) begin
      r_lane_cnt <= r_lane_cnt + LW'(1);
      r_pack     <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_complete) begin
      r_mem_data[r_wr_ptr] <= w_word;
      r_mem_keep[r_wr_ptr] <= w_keep;
      r_mem_last[r_wr_ptr] <= in_last;
    end
  end

  // A push can never coincide with full, since in_ready is !full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_complete) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_complete, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_data = m_valid ? r_mem_data[r_rd_ptr] : '0;
  assign m_keep = m_valid ? r_mem_keep[r_rd_ptr] : '0;
  assign m_last = m_valid ? r_mem_last[r_rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;

`ifdef QUANT_PACK_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge clk) begin
    if (rst)                                  r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: doc/quant_pack.md
QUANT_PACK -- requirements
Module: quant_pack

Interface
REQ-001 The block SHALL have parameter D_W, default 8, meaning width of one quantised element in bits.
REQ-002 The block SHALL have parameter LANES, default 4, meaning number of elements packed per output word.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output word FIFO depth, a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous, active-high.
REQ-006 The block SHALL have port in_data, input, D_W bits, meaning signed quantised element from the requant stage.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning in_data is valid this cycle.
REQ-008 The block SHALL have port in_last, input, 1 bit, meaning the element is the last of a row.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept an element; it drives the requant back_ready_in.
REQ-010 The block SHALL have port m_data, output, D_W*LANES bits, meaning the packed output word.
REQ-011 The block SHALL have port m_keep, output, LANES bits, meaning the per-lane byte-valid mask.
REQ-012 The block SHALL have port m_valid, output, 1 bit, meaning the output word is valid.
REQ-013 The block SHALL have port m_last, output, 1 bit, meaning the word closes a row.
REQ-014 The block SHALL have port m_ready, input, 1 bit, meaning the downstream sink accepts the word.
REQ-015 The block SHALL have port ovf, output, 1 bit, meaning a sticky flag that an element was dropped.
REQ-016 The block SHALL have port drop_cnt, output, 16 bits, meaning the dropped-element count (see Configuration).

Function
REQ-017 An element SHALL be accepted when in_valid && in_ready, which is a cycle called "accept".
REQ-018 in_ready SHALL be combinational: in_ready = !fifo_full.
REQ-019 An element offered with in_valid && !in_ready SHALL be discarded and SHALL set ovf on the next edge; the lane state SHALL be unchanged.
REQ-020 Lane counter lane_cnt (0..LANES-1) SHALL select the destination lane: an accepted element SHALL be written to bits [lane_cnt*D_W +: D_W] of the pack register, little-endian, lane 0 in the LSBs.
REQ-021 A word SHALL complete on an accept with lane_cnt==LANES-1 or with in_last=1.
REQ-022 On completion, {pack word, keep, last} SHALL be pushed into the FIFO on the same edge, and lane_cnt SHALL return to 0.
REQ-023 The keep value SHALL have bits 0..lane_cnt set; last SHALL equal in_last.
REQ-024 Lanes above lane_cnt in a partial word SHALL be zero.
REQ-025 Example: a last element at lane_cnt=1 SHALL produce keep 4'b0011.
REQ-026 Otherwise an accept SHALL increment lane_cnt by 1.
REQ-027 Latency: m_valid SHALL assert in the cycle after the completing accept when the FIFO was empty.
REQ-028 m_data, m_keep and m_last SHALL present the FIFO head whenever m_valid=1.
REQ-029 A pop SHALL occur on m_valid && m_ready.
REQ-030 Simultaneous push and pop SHALL leave the FIFO count unchanged; push while full cannot occur (REQ-018).
REQ-031 The head SHALL be held stable while m_valid && !m_ready.
REQ-032 The read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be held in log2(FIFO_DEPTH)+1 bits.
REQ-033 ovf SHALL be cleared only by rst.

Reset
REQ-034 While rst=1 on an edge, lane_cnt, the pack register, the FIFO pointers and count, ovf and drop_cnt SHALL clear to 0.
REQ-035 After reset: m_valid=0, m_last=0, m_keep=0, m_data=0, and in_ready=1.
REQ-036 Reset mid-word SHALL discard the partial word without emitting it; reset with the FIFO non-empty SHALL discard all stored words.

Configuration
REQ-037 Macro QUANT_PACK_DROP_CNT_EN SHALL control the drop counter.
REQ-038 With QUANT_PACK_DROP_CNT_EN defined, drop_cnt SHALL increment by 1 per discarded element (REQ-019) and SHALL saturate at 16'hFFFF.
REQ-039 Without QUANT_PACK_DROP_CNT_EN, drop_cnt SHALL be tied to 16'h0000 with no counter logic; ovf SHALL still function.

Verification
REQ-040 Scenario: elements 0x01,0x02,0x03,0x84 on consecutive cycles, last on 0x84, m_ready=1 -> one word 0x84030201, keep 4'b1111, m_last=1, m_valid one cycle after 0x84.
REQ-041 Scenario: elements 0x7F,0x80 with last on 0x80 -> word 0x0000807F, keep 4'b0011, m_last=1; the next element lands in lane 0.
REQ-042 Scenario: m_ready=0, 16 elements streamed -> 4 words stored, in_ready=0 after the 16th accept; 3 more offered -> ovf=1, drop_cnt=3 (macro on) or 0 (macro off); with m_ready=1, the 4 words exit in order.
REQ-043 Scenario: FIFO holds 1 word, m_ready=1, and a completing accept in the same cycle -> count stays 1 and no word is lost or duplicated.
REQ-044 Scenario: rst asserted after 2 accepts -> no word is emitted; the next 4 elements form a fresh word in lanes 0..3.
REQ-045 Scenario: macro on, 70000 drops -> drop_cnt=16'hFFFF.
